// File: rtl/dcnt10_ld.sv
// Loadable down-counter with terminal-count pulse, sticky flag and optional
// auto-reload from a shadow register captured on every parallel load.
module dcnt10_ld #(
    parameter int WIDTH     = 10,
    parameter bit RELOAD_EN = 1'b1
) (
    input  logic             CLK,
    input  logic             CDN,
    input  logic             LD,
    input  logic             CE,
    input  logic [WIDTH-1:0] D,
    input  logic             CLR,
    output logic [WIDTH-1:0] Q,
    output logic             ZN0,
    output logic             TC,
    output logic             STK
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             tc_q, tc_d;
    logic             stk_q, stk_d;

    // Priority is load, then count, then hold. Counting from zero never wraps.
    always_comb begin
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        tc_d     = 1'b0;
        if (LD) begin
            cnt_d    = D;
            shadow_d = D;
        end else if (CE) begin
            if (cnt_q == WIDTH'(1)) begin
                cnt_d = '0;
                tc_d  = 1'b1;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - WIDTH'(1);
            end else if (RELOAD_EN) begin
                cnt_d = shadow_q;
            end
        end
        stk_d = tc_d | (stk_q & ~CLR);
    end

    always_ff @(posedge CLK or negedge CDN) begin
        if (!CDN) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            tc_q     <= 1'b0;
            stk_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            tc_q     <= tc_d;
            stk_q    <= stk_d;
        end
    end

    assign Q   = cnt_q;
    assign ZN0 = ~|cnt_q;
    assign TC  = tc_q;
    assign STK = stk_q;

endmodule
